sram_bus_responder: RTL and testbench

//   On-chip responder for the 16-bit asynchronous SRAM bus driven by the Mips core
//   (addr, dq, we_n, oe_n, ub_n, lb_n, ce_n).

---
 rtl/sram_bus_responder.sv | 97 +++++++++
 tb/tb_sram_bus_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_responder.sv
// sram_bus_responder: block-RAM emulation of a 16-bit async SRAM with programmable read wait states.
// Optional bus protocol checker enabled by defining SRAM_RESP_CHECK_EN (adds bus_err_o).
module sram_bus_responder #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 2
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic [17:0] addr_i,
  inout  wire  [15:0] dq_io,
  input  logic        we_ni,
  input  logic        oe_ni,
  input  logic        ub_ni,
  input  logic        lb_ni,
  input  logic        ce_ni,
  output logic        rd_ready_o,
  output logic        busy_o
`ifdef SRAM_RESP_CHECK_EN
  ,
  output logic        bus_err_o
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE} state_e;
  localparam logic [3:0] RELOAD = 4'(READ_LAT - 1);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [17:0] raddr_q, raddr_d;
  logic [15:0] mem_q [2**ADDR_W];
  logic [15:0] rdata;
  logic        wr, rd, addr_chg, drive_en;
  assign wr       = !ce_ni && !we_ni;
  assign rd       = !ce_ni && we_ni && !oe_ni;
  assign addr_chg = addr_i != raddr_q;
  assign rdata    = mem_q[raddr_q[ADDR_W-1:0]];
  // Drive is gated by the live strobes so the bus turns around without waiting for an edge.
  assign drive_en = (state_q == S_DRIVE) && rd;
  assign dq_io[15:8] = (drive_en && !ub_ni) ? rdata[15:8] : 8'hzz;
  assign dq_io[7:0]  = (drive_en && !lb_ni) ? rdata[7:0]  : 8'hzz;
  assign rd_ready_o  = state_q == S_DRIVE;
  assign busy_o      = state_q == S_WAIT;
  // Byte-lane writes; blocked while reset is held so a reset mid-cycle cannot corrupt memory.
  always_ff @(posedge clock_i) begin
    if (reset_ni && wr) begin
      if (!ub_ni) mem_q[addr_i[ADDR_W-1:0]][15:8] <= dq_io[15:8];
      if (!lb_ni) mem_q[addr_i[ADDR_W-1:0]][7:0]  <= dq_io[7:0];
    end
  end
  // Read FSM state, wait counter and latched read address.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
    end
  end
  // Next state: writes and dropped reads abort, a new or changed address restarts the wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    if (wr || !rd) begin
      state_d = S_IDLE;
    end else if (state_q == S_IDLE || addr_chg) begin
      state_d = S_WAIT;
      cnt_d   = RELOAD;
      raddr_d = addr_i;
    end else if (state_q == S_WAIT) begin
      if (cnt_q == 4'd0) state_d = S_DRIVE;
      else cnt_d = cnt_q - 4'd1;
    end
  end
`ifdef SRAM_RESP_CHECK_EN
  logic        err_q, err_d, wr_q;
  logic [17:0] waddr_q;
  assign err_d     = err_q || (wr && !oe_ni) || (wr && wr_q && addr_i != waddr_q);
  assign bus_err_o = err_q;
  // Sticky protocol error: output-enable during write, or address moving under a held write strobe.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
    end else begin
      err_q   <= err_d;
      wr_q    <= wr;
      waddr_q <= addr_i;
`ifndef SYNTHESIS
      if (err_d && !err_q) $display("sram_bus_responder: bus error at %0t addr %h", $time, addr_i);
`endif
    end
  end
`endif
endmodule

// File: tb/tb_sram_bus_responder.sv
// tb_sram_bus_responder: directed table-driven check of the SRAM bus responder (ADDR_W=10, READ_LAT=2).
module tb_sram_bus_responder;
  typedef struct {
    logic        ce_n, we_n, oe_n, ub_n, lb_n, drv;
    logic [17:0] addr;
    logic [15:0] wdata, exp_dq;
    logic        exp_rdy, exp_busy;
  } vec_t;
  localparam logic [15:0] Z = 16'hFFFF;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] addr = '0;
  logic        we_n = 1'b1, oe_n = 1'b1, ub_n = 1'b0, lb_n = 1'b0, ce_n = 1'b1;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_wdata = '0;
  logic        rd_ready, busy;
  tri1  [15:0] dq;
  int          n_cmp = 0, n_err = 0;
  vec_t        tv[36];
`ifdef SRAM_RESP_CHECK_EN
  logic        bus_err;
`endif
  assign dq = tb_drv ? tb_wdata : 16'hzzzz;
  always #5 clk = ~clk;
  sram_bus_responder #(.ADDR_W(10), .READ_LAT(2)) dut (
    .clock_i(clk), .reset_ni(reset_n), .addr_i(addr), .dq_io(dq),
    .we_ni(we_n), .oe_ni(oe_n), .ub_ni(ub_n), .lb_ni(lb_n), .ce_ni(ce_n),
    .rd_ready_o(rd_ready), .busy_o(busy)
`ifdef SRAM_RESP_CHECK_EN
    , .bus_err_o(bus_err)
`endif
  );
  function automatic vec_t wrv(logic [17:0] a, logic [15:0] d, logic ub, logic lb);
    vec_t v;
    v.ce_n = 0; v.we_n = 0; v.oe_n = 1; v.ub_n = ub; v.lb_n = lb; v.drv = 1;
    v.addr = a; v.wdata = d; v.exp_dq = d; v.exp_rdy = 0; v.exp_busy = 0;
    return v;
  endfunction
  function automatic vec_t rdv(logic [17:0] a, logic ub, logic lb, logic [15:0] q, logic r, logic b);
    vec_t v;
    v.ce_n = 0; v.we_n = 1; v.oe_n = 0; v.ub_n = ub; v.lb_n = lb; v.drv = 0;
    v.addr = a; v.wdata = '0; v.exp_dq = q; v.exp_rdy = r; v.exp_busy = b;
    return v;
  endfunction
  function automatic vec_t idv();
    vec_t v;
    v.ce_n = 1; v.we_n = 1; v.oe_n = 1; v.ub_n = 0; v.lb_n = 0; v.drv = 0;
    v.addr = '0; v.wdata = '0; v.exp_dq = Z; v.exp_rdy = 0; v.exp_busy = 0;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    ce_n = v.ce_n; we_n = v.we_n; oe_n = v.oe_n; ub_n = v.ub_n; lb_n = v.lb_n;
    addr = v.addr; tb_drv = v.drv; tb_wdata = v.wdata;
  endtask
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    chk({nm, ".dq"}, dq, v.exp_dq);
    chk({nm, ".rdy"}, {15'd0, rd_ready}, {15'd0, v.exp_rdy});
    chk({nm, ".busy"}, {15'd0, busy}, {15'd0, v.exp_busy});
  endtask
  initial begin
    tv[0]  = wrv(18'h005, 16'hBEEF, 0, 0);
    tv[1]  = rdv(18'h005, 0, 0, Z, 0, 1);
    tv[2]  = rdv(18'h005, 0, 0, Z, 0, 1);
    tv[3]  = rdv(18'h005, 0, 0, 16'hBEEF, 1, 0);
    tv[4]  = rdv(18'h005, 0, 0, 16'hBEEF, 1, 0);
    tv[5]  = idv();
    tv[6]  = wrv(18'h010, 16'h1234, 0, 0);
    tv[7]  = wrv(18'h010, 16'hAB00, 0, 1);
    tv[8]  = rdv(18'h010, 0, 0, Z, 0, 1);
    tv[9]  = rdv(18'h010, 0, 0, Z, 0, 1);
    tv[10] = rdv(18'h010, 0, 0, 16'hAB34, 1, 0);
    tv[11] = rdv(18'h010, 1, 0, 16'hFF34, 1, 0);
    tv[12] = idv();
    tv[13] = wrv(18'h001, 16'h1111, 0, 0);
    tv[14] = wrv(18'h002, 16'h2222, 0, 0);
    tv[15] = rdv(18'h001, 0, 0, Z, 0, 1);
    tv[16] = rdv(18'h002, 0, 0, Z, 0, 1);
    tv[17] = rdv(18'h002, 0, 0, Z, 0, 1);
    tv[18] = rdv(18'h002, 0, 0, 16'h2222, 1, 0);
    tv[19] = idv();
    tv[20] = wrv(18'h400, 16'h5A5A, 0, 0);
    tv[21] = rdv(18'h000, 0, 0, Z, 0, 1);
    tv[22] = rdv(18'h000, 0, 0, Z, 0, 1);
    tv[23] = rdv(18'h000, 0, 0, 16'h5A5A, 1, 0);
    tv[24] = rdv(18'h005, 0, 0, Z, 0, 1);
    tv[25] = rdv(18'h005, 0, 0, Z, 0, 1);
    tv[26] = rdv(18'h005, 0, 0, 16'hBEEF, 1, 0);
    tv[27] = rdv(18'h001, 0, 0, Z, 0, 1);
    tv[28] = idv();
    tv[29] = rdv(18'h000, 0, 0, Z, 0, 1);
    tv[30] = rdv(18'h000, 0, 0, Z, 0, 1);
    tv[31] = rdv(18'h000, 0, 0, 16'h5A5A, 1, 0);
    tv[32] = wrv(18'h005, 16'h0000, 1, 1);
    tv[33] = rdv(18'h005, 0, 0, Z, 0, 1);
    tv[34] = rdv(18'h005, 0, 0, Z, 0, 1);
    tv[35] = rdv(18'h005, 0, 0, 16'hBEEF, 1, 0);
    drive(idv());
    repeat (2) @(posedge clk);
    #1;
    chk("rst.dq", dq, Z);
    chk("rst.rdy", {15'd0, rd_ready}, 16'd0);
    chk("rst.busy", {15'd0, busy}, 16'd0);
`ifdef SRAM_RESP_CHECK_EN
    chk("rst.err", {15'd0, bus_err}, 16'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) step(idv(), $sformatf("idle%0d", i));
    for (int i = 0; i < 36; i++) step(tv[i], $sformatf("vec%0d", i));
    @(negedge clk);
    oe_n = 1'b1;
    #1;
    chk("oe_release.dq", dq, Z);
    chk("oe_release.rdy", {15'd0, rd_ready}, 16'd1);
    @(posedge clk);
    #1;
    chk("oe_release.idle", {15'd0, rd_ready}, 16'd0);
    step(rdv(18'h000, 0, 0, Z, 0, 1), "re1a");
    step(rdv(18'h000, 0, 0, Z, 0, 1), "re1b");
    step(rdv(18'h000, 0, 0, 16'h5A5A, 1, 0), "re1c");
    @(negedge clk);
    we_n = 1'b0;
    #1;
    chk("we_release.dq", dq, Z);
    ce_n = 1'b1;
    we_n = 1'b1;
    @(posedge clk);
    #1;
    chk("we_release.idle", {15'd0, rd_ready}, 16'd0);
    step(rdv(18'h000, 0, 0, Z, 0, 1), "re2a");
    step(rdv(18'h000, 0, 0, Z, 0, 1), "re2b");
    step(rdv(18'h000, 0, 0, 16'h5A5A, 1, 0), "re2c");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst.dq", dq, Z);
    chk("midrst.rdy", {15'd0, rd_ready}, 16'd0);
    chk("midrst.busy", {15'd0, busy}, 16'd0);
    drive(wrv(18'h000, 16'h0000, 0, 0));
    @(posedge clk);
    #1;
    chk("midrst.hold", {14'd0, rd_ready, busy}, 16'd0);
    @(negedge clk);
    drive(idv());
    reset_n = 1'b1;
    step(rdv(18'h000, 0, 0, Z, 0, 1), "re3a");
    step(rdv(18'h000, 0, 0, Z, 0, 1), "re3b");
    step(rdv(18'h000, 0, 0, 16'h5A5A, 1, 0), "re3c");
`ifdef SRAM_RESP_CHECK_EN
    step(idv(), "err_pre");
    chk("err.clear", {15'd0, bus_err}, 16'd0);
    @(negedge clk);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; addr = 18'h3FF;
    @(posedge clk);
    #1;
    chk("err.set", {15'd0, bus_err}, 16'd1);
    step(idv(), "err_idle");
    chk("err.sticky", {15'd0, bus_err}, 16'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("err.reset", {15'd0, bus_err}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
